// File: rtl/simon_fsm_gen.sv
// Simon game controller: fills an external sequence memory from a random source,
// plays back rounds on the LEDs, checks player presses, and tracks best score and win.
module simon_fsm_gen #(
   parameter int NUM_COLORS    = 4,
   parameter int MAX_LEN       = 16,
   parameter int ON_TICKS      = 4,
   parameter int OFF_TICKS     = 2,
   parameter int TIMEOUT_TICKS = 64,
   localparam int CW = ($clog2(NUM_COLORS) > 1) ? $clog2(NUM_COLORS) : 1,
   localparam int AW = $clog2(MAX_LEN),
   localparam int LW = $clog2(MAX_LEN + 1)
) (
   input  logic                  clk_tick,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [CW-1:0]         rnd_val,
   output logic                  rnd_enable,
   output logic                  write_en,
   output logic [AW-1:0]         wr_addr,
   output logic [CW-1:0]         wr_data,
   output logic [AW-1:0]         rd_addr,
   input  logic [CW-1:0]         rd_data,
   input  logic                  btn_valid,
   input  logic [CW-1:0]         btn_val,
   output logic [NUM_COLORS-1:0] led,
   output logic                  error_led,
   output logic                  win_led,
   output logic [LW-1:0]         level,
   output logic [LW-1:0]         best_level,
   output logic [2:0]            state
);

   localparam int TMAX_AB = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int TMAX    = (TMAX_AB > TIMEOUT_TICKS) ? TMAX_AB : TIMEOUT_TICKS;
   localparam int TW      = $clog2(TMAX + 1);
   localparam logic [CW:0] NC = (CW+1)'(NUM_COLORS);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INIT     = 3'd1,
      SHOW_ON  = 3'd2,
      SHOW_OFF = 3'd3,
      WAIT     = 3'd4,
      CHECK    = 3'd5,
      ERROR    = 3'd6,
      WIN      = 3'd7
   } state_t;

   state_t          cur;
   logic [LW-1:0]   init_idx;
   logic [LW-1:0]   play_idx;
   logic [LW-1:0]   input_idx;
   logic [TW-1:0]   timer;
   logic [CW-1:0]   latched;

   logic [CW-1:0]         rnd_mod;
   logic [NUM_COLORS-1:0] rd_onehot;
   logic                  press_ok;
   logic                  last_press;

   // Random values can exceed the colour range by less than NUM_COLORS, so one subtract folds them.
   assign rnd_mod    = ({1'b0, rnd_val} >= NC) ? CW'({1'b0, rnd_val} - NC) : rnd_val;
   assign rd_onehot  = NUM_COLORS'(1) << rd_data;
   assign press_ok   = ({1'b0, latched} < NC) && (latched == rd_data);
   assign last_press = (input_idx + 1'b1) == level;
   assign state      = cur;

   always_ff @(posedge clk_tick or negedge reset_n) begin
      if (!reset_n) begin
         cur        <= IDLE;
         rnd_enable <= 1'b0;
         write_en   <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         rd_addr    <= '0;
         led        <= '0;
         error_led  <= 1'b0;
         win_led    <= 1'b0;
         level      <= '0;
         best_level <= '0;
         init_idx   <= '0;
         play_idx   <= '0;
         input_idx  <= '0;
         timer      <= '0;
         latched    <= '0;
      end else begin
         write_en   <= 1'b0;
         rnd_enable <= 1'b0;
         case (cur)
            IDLE: begin
               if (start) begin
                  cur      <= INIT;
                  init_idx <= '0;
                  level    <= '0;
               end
            end
            INIT: begin
               if (init_idx < LW'(MAX_LEN)) begin
                  write_en   <= 1'b1;
                  rnd_enable <= 1'b1;
                  wr_addr    <= AW'(init_idx);
                  wr_data    <= rnd_mod;
                  init_idx   <= init_idx + 1'b1;
               end else begin
                  cur      <= SHOW_ON;
                  level    <= LW'(1);
                  play_idx <= '0;
                  rd_addr  <= '0;
                  timer    <= '0;
               end
            end
            SHOW_ON: begin
               led <= rd_onehot;
               if (timer == TW'(ON_TICKS - 1)) begin
                  timer <= '0;
                  cur   <= SHOW_OFF;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            SHOW_OFF: begin
               led <= '0;
               if (timer == TW'(OFF_TICKS - 1)) begin
                  timer    <= '0;
                  play_idx <= play_idx + 1'b1;
                  if ((play_idx + 1'b1) == level) begin
                     cur       <= WAIT;
                     input_idx <= '0;
                     rd_addr   <= '0;
                  end else begin
                     cur     <= SHOW_ON;
                     rd_addr <= AW'(play_idx + 1'b1);
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            WAIT: begin
               led <= '0;
               // A press on the final timeout cycle still counts as a press.
               if (btn_valid) begin
                  latched <= btn_val;
                  cur     <= CHECK;
               end else if (timer == TW'(TIMEOUT_TICKS - 1)) begin
                  cur       <= ERROR;
                  error_led <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            CHECK: begin
               if (press_ok) begin
                  if (!last_press) begin
                     input_idx <= input_idx + 1'b1;
                     rd_addr   <= rd_addr + 1'b1;
                     timer     <= '0;
                     cur       <= WAIT;
                  end else begin
                     if (level > best_level) best_level <= level;
                     if (level == LW'(MAX_LEN)) begin
                        cur     <= WIN;
                        win_led <= 1'b1;
                        led     <= '1;
                     end else begin
                        level    <= level + 1'b1;
                        play_idx <= '0;
                        rd_addr  <= '0;
                        timer    <= '0;
                        cur      <= SHOW_ON;
                     end
                  end
               end else begin
                  cur       <= ERROR;
                  error_led <= 1'b1;
               end
            end
            ERROR: begin
               led <= '0;
               if (start) begin
                  cur       <= INIT;
                  init_idx  <= '0;
                  level     <= '0;
                  error_led <= 1'b0;
               end else if (btn_valid) begin
                  cur       <= SHOW_ON;
                  level     <= LW'(1);
                  play_idx  <= '0;
                  rd_addr   <= '0;
                  timer     <= '0;
                  error_led <= 1'b0;
               end
            end
            WIN: begin
               if (start) begin
                  cur      <= INIT;
                  init_idx <= '0;
                  level    <= '0;
                  win_led  <= 1'b0;
                  led      <= '0;
               end else if (btn_valid) begin
                  cur     <= IDLE;
                  level   <= '0;
                  win_led <= 1'b0;
                  led     <= '0;
               end
            end
            default: cur <= IDLE;
         endcase
      end
   end

endmodule
